// File: rtl/byte_lsu.sv
// Byte-serial load/store sequencer: splits one byte/half/word core request into
// little-endian single-byte RAM beats and returns a sign/zero-extended load result.
module byte_lsu #(
    parameter int ADDR_W      = 8,
    parameter int XLEN        = 32,
    parameter int ALIGN_CHECK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_wd,
    output logic              ram_we,
    input  logic [7:0]        ram_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nx;
    logic              l_we, l_uns;
    logic [1:0]        l_size, k, last_k;
    logic [ADDR_W-1:0] l_addr;
    logic [XLEN-1:0]   l_wdata, asm_buf, asm_w, ext;
    logic              req_bad, last_beat;

    assign req_bad = (req_size == 2'b11) ||
                     ((ALIGN_CHECK != 0) &&
                      (((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))));

    assign last_k    = (l_size == 2'b00) ? 2'd0 : (l_size == 2'b01) ? 2'd1 : 2'd3;
    assign last_beat = (k == last_k);

    // Buffer with the byte arriving this beat merged in, so the final beat can
    // feed the registered response directly.
    always_comb begin
        asm_w = asm_buf;
        asm_w[{k, 3'b000} +: 8] = ram_rd;
    end

    always_comb begin
        ext = asm_w;
        case (l_size)
            2'b00:   ext = {{(XLEN-8){~l_uns & asm_w[7]}}, asm_w[7:0]};
            2'b01:   ext = {{(XLEN-16){~l_uns & asm_w[15]}}, asm_w[15:0]};
            default: ext = asm_w;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        ram_a     = '0;
        ram_wd    = '0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                ram_a  = l_addr + ADDR_W'(k);
                ram_we = l_we;
                ram_wd = l_we ? l_wdata[{k, 3'b000} +: 8] : 8'h00;
                if (last_beat) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_we       <= 1'b0;
            l_uns      <= 1'b0;
            l_size     <= 2'b00;
            l_addr     <= '0;
            l_wdata    <= '0;
            k          <= 2'd0;
            asm_buf    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    l_we    <= req_we;
                    l_uns   <= req_unsigned;
                    l_size  <= req_size;
                    l_addr  <= req_addr;
                    l_wdata <= req_wdata;
                    k       <= 2'd0;
                    asm_buf <= '0;
                    if (req_bad) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (!l_we) asm_buf <= asm_w;
                    if (last_beat) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= l_we ? '0 : ext;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lsu.sv
// Scoreboard bench for byte_lsu: two instances (alignment checking off/on) share
// one request stream; each has its own RAM and its own reference memory image.
module tb_byte_lsu;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    logic        rdy0, rv0, re0, rwe0, rdy1, rv1, re1, rwe1;
    logic [31:0] rd0, rd1;
    logic [7:0]  ra0, rwd0, rrd0, ra1, rwd1, rrd1;

    logic [7:0]  mem0 [256] = '{default: 8'h00};
    logic [7:0]  mem1 [256] = '{default: 8'h00};
    logic [7:0]  refm [2][256] = '{default: '{default: 8'h00}};

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byte_lsu #(.ADDR_W(8), .XLEN(32), .ALIGN_CHECK(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv0), .resp_err(re0), .resp_rdata(rd0),
        .ram_a(ra0), .ram_wd(rwd0), .ram_we(rwe0), .ram_rd(rrd0));

    byte_lsu #(.ADDR_W(8), .XLEN(32), .ALIGN_CHECK(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1),
        .ram_a(ra1), .ram_wd(rwd1), .ram_we(rwe1), .ram_rd(rrd1));

    assign rrd0 = mem0[ra0];
    assign rrd1 = mem1[ra1];
    always @(posedge clk) begin
        if (rwe0) mem0[ra0] <= rwd0;
        if (rwe1) mem1[ra1] <= rwd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bytes at (addr+k) mod 256, little-endian, extension by value range.
    function automatic exp_t model(input int d, input bit we, input logic [1:0] sz,
                                   input bit uns, input logic [7:0] a, input logic [31:0] wd);
        exp_t   e;
        int     n;
        longint v;
        e.err = 1'b0; e.rdata = 32'h0; e.cyc = 0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        if (n == 0 || (d == 1 && (int'(a) % n) != 0)) begin
            e.err = 1'b1;
            return e;
        end
        v = 0;
        for (int k = 0; k < n; k++) begin
            int ad = (int'(a) + k) % 256;
            if (we) refm[d][ad] = 8'((wd >> (8 * k)) & 32'hFF);
            else    v += longint'(refm[d][ad]) * (longint'(1) << (8 * k));
        end
        if (!we) begin
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
            e.rdata = v[31:0];
        end
        e.cyc = n;
        return e;
    endfunction

    task automatic resp_chk(input int d, input logic err, input logic [31:0] rd);
        exp_t e;
        tests++;
        if (d == 0 ? q0.size() == 0 : q1.size() == 0) begin
            fails++;
            $display("FAIL resp%0d_unexpected: got err=%b rdata=%h at cyc %0d, required no response",
                     d, err, rd, cyc);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (err !== e.err || rd !== e.rdata || cyc != e.cyc) begin
            fails++;
            $display("FAIL resp%0d: got err=%b rdata=%h cyc=%0d required err=%b rdata=%h cyc=%0d",
                     d, err, rd, cyc, e.err, e.rdata, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rv0) resp_chk(0, re0, rd0);
            if (rv1) resp_chk(1, re1, rd1);
        end
    end

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd, input bit expect_resp);
        int   t = 0;
        int   c0;
        exp_t e;
        @(negedge clk);
        while (!(rdy0 && rdy1)) begin
            if (t++ > 50) begin
                tests++; fails++;
                $display("FAIL ready_timeout: got rdy0=%b rdy1=%b required 1", rdy0, rdy1);
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c0 = cyc;
        if (expect_resp) begin
            e = model(0, we, sz, uns, a, wd); e.cyc += c0; q0.push_back(e);
            e = model(1, we, sz, uns, a, wd); e.cyc += c0; q1.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            if (t++ > 100) begin
                tests++; fails++;
                $display("FAIL drain_timeout: got %0d/%0d pending responses, required 0",
                         q0.size(), q1.size());
                q0.delete(); q1.delete();
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int   c0;
        exp_t e;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {rdy0, rdy1}, 2'b11);
        chk("reset_resp", {rv0, re0, rv1, re1}, 4'b0000);
        chk("reset_rdata", rd0 | rd1, 32'h0);
        chk("reset_ram", {rwe0, rwe1, ra0, rwd0, ra1, rwd1}, 34'h0);
        rst = 1'b1;

        // Reset mid word store: bytes 0..1 land, 2..3 keep the old pattern
        issue(1, 2'b10, 0, 8'h40, 32'hA5A5A5A5, 1);
        drain();
        issue(1, 2'b10, 0, 8'h40, 32'h44332211, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t1_ram_we", {rwe0, rwe1}, 2'b00);
        chk("t1_ready", {rdy0, rdy1}, 2'b11);
        chk("t1_no_resp", {rv0, rv1}, 2'b00);
        chk("t1_mem0", {mem0[8'h43], mem0[8'h42], mem0[8'h41], mem0[8'h40]}, 32'hA5A52211);
        chk("t1_mem1", {mem1[8'h43], mem1[8'h42], mem1[8'h41], mem1[8'h40]}, 32'hA5A52211);
        for (int d = 0; d < 2; d++) begin
            refm[d][8'h40] = 8'h11;
            refm[d][8'h41] = 8'h22;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(0, 2'b10, 0, 8'h40, 32'h0, 1);

        // Word store then load
        issue(1, 2'b10, 0, 8'h10, 32'hDEADBEEF, 1);
        drain();
        chk("t2_mem0", {mem0[8'h13], mem0[8'h12], mem0[8'h11], mem0[8'h10]}, 32'hDEADBEEF);
        issue(0, 2'b10, 0, 8'h10, 32'h0, 1);

        // Signed / unsigned bytes and halves
        issue(1, 2'b00, 0, 8'h20, 32'h00000080, 1);
        issue(1, 2'b00, 0, 8'h21, 32'h0000007F, 1);
        issue(0, 2'b00, 0, 8'h20, 32'h0, 1);
        issue(0, 2'b00, 1, 8'h20, 32'h0, 1);
        issue(0, 2'b01, 0, 8'h20, 32'h0, 1);
        issue(0, 2'b01, 1, 8'h20, 32'h0, 1);
        issue(0, 2'b01, 0, 8'h21, 32'h0, 1);

        // Address wrap; misaligned for the checking instance
        issue(1, 2'b10, 0, 8'hFE, 32'h11223344, 1);
        drain();
        chk("t4_wrap", {mem0[8'h01], mem0[8'h00], mem0[8'hFF], mem0[8'hFE]}, 32'h11223344);
        issue(0, 2'b10, 1, 8'hFE, 32'h0, 1);

        // Errors: illegal size never writes; odd half errors only with checking on
        issue(1, 2'b11, 0, 8'h30, 32'hFFFFFFFF, 1);
        chk("t5_no_we", {rwe0, rwe1}, 2'b00);
        issue(0, 2'b01, 0, 8'h03, 32'h0, 1);
        drain();

        // req_valid held through a word load: second accept only when ready returns
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 8'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        c0 = cyc;
        for (int d = 0; d < 2; d++) begin
            e = model(d, 0, 2'b10, 0, 8'h10, 32'h0); e.cyc += c0;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            e.cyc += 6;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        repeat (6) @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 1) ? $urandom_range(0, 23) : $urandom_range(0, 255)),
                  $urandom, 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
